alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator for the ALU_DESIGN port set. Takes one ALU operation per valid/ready request.
//  Drives CE, MODE, CMD, INP_VALID, CIN, OPA and OPB, including split-operand issue
//  (OPA beat, idle gap, OPB beat). Waits the command-dependent ALU latency, captures
//  RES and the flags, and returns them on a valid/ready response port. Sits between a
//  command source (CPU/DMA shim) and an ALU_DESIGN instance.
// PARAMETERS
//  DW       8   operand width; matches ALU DW
//  CW       4   command width; matches ALU CW
//  LAT      1   result latency in cycles for non-multiply commands
//  MUL_LAT  2   result latency for multiply commands (MODE=1, CMD=9 or 10)
//  MAX_GAP  14  clamp for split gap; must stay below the ALU 16-cycle operand timeout
// PORTS
//  CLK        in   1      clock
//  RST        in   1      synchronous reset, active-high
//  req_valid  in   1      request valid
//  req_ready  out  1      request ready; high only in IDLE
//  req_mode   in   1      MODE to issue (1 = arithmetic, 0 = logical)
//  req_cmd    in   CW     CMD to issue
//  req_opa    in   DW     operand A
//  req_opb    in   DW     operand B
//  req_cin    in   1      carry in
//  req_split  in   1      1 = issue OPA and OPB as separate beats
//  req_gap    in   4      idle cycles between split beats (clamped to MAX_GAP)
//  CE MODE CIN out 1 each  ALU controls
//  CMD        out  CW     ALU command
//  INP_VALID  out  2      ALU operand-valid: 00 none, 01 A, 10 B, 11 both
//  OPA OPB    out  DW     ALU operands; held for the whole operation
//  RES        in   2*DW   ALU result
//  COUT OFLOW G L E ERR  in  1 each  ALU flags
//  rsp_valid  out  1      response valid
//  rsp_ready  in   1      response ready
//  rsp_res    out  2*DW   captured RES
//  rsp_flags  out  5      {COUT,OFLOW,G,L,E} captured
//  rsp_err    out  1      captured ERR
// BEHAVIOUR
//  Reset: CLK is the only clock. RST is synchronous and active-high. While RST is high,
//   and on the cycle after, state=IDLE and every output is 0 (req_ready=0 during RST).
//   Reset mid-operation abandons the operation: no response is produced and CE drops.
//  FSM: IDLE -> ISSUE_A -> GAP -> ISSUE_B -> WAIT -> RESP -> IDLE.
//   Unsplit operations skip ISSUE_A and GAP.
//  IDLE: req_ready=1, CE=0, INP_VALID=00. On req_valid, all req_* are registered
//   (gap = min(req_gap, MAX_GAP)), latency = MUL_LAT if mode=1 && cmd in {9,10},
//   else LAT. Next state is ISSUE_B if !split, else ISSUE_A.
//  ISSUE_A: INP_VALID=01 for 1 cycle. Go to GAP if gap>0, else ISSUE_B.
//  GAP: INP_VALID=00 for gap cycles (down-counter).
//  ISSUE_B: INP_VALID=11 if unsplit, 10 if split, for 1 cycle.
//  WAIT: INP_VALID=00 for latency cycles. RES, flags and ERR are captured on the clock
//   edge ending the last WAIT cycle.
//  RESP: rsp_valid=1 with stable data until rsp_ready; the handshake cycle moves to IDLE.
//  CE=1 in ISSUE_A, GAP, ISSUE_B and WAIT; CE=0 in IDLE and RESP.
//  MODE, CMD, CIN, OPA and OPB are driven from the registered request in every non-IDLE
//   state, and are 0 in IDLE.
//  Timing: unsplit LAT=1 gives accept at edge 0, ISSUE_B in cycle 1, WAIT in cycle 2,
//   rsp_valid in cycle 3. Minimum request-to-request spacing is 4 cycles.
//  rsp_valid and req_ready are never high together. A request presented during RESP waits.
// TESTING
//  1 Unsplit ADD: mode=1, cmd=0, opa=200, opb=100, cin=0 -> INP_VALID=11 in cycle 1 only;
//    rsp_valid in cycle 3; rsp_res=300 (0x12C); rsp_err=0.
//  2 Split, gap=3: INP_VALID trace 01,00,00,00,10 then 00 (WAIT); OPA=opa held throughout;
//    rsp_valid 7 cycles after accept.
//  3 Multiply: mode=1, cmd=9, opa=5, opb=6 -> WAIT lasts 2 cycles; rsp_valid one cycle later
//    than test 1; rsp_res equals the RES the ALU presents at capture.
//  4 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, CE=0;
//    IDLE on the cycle after rsp_ready=1.
//  5 RST pulsed during WAIT of a split op -> next cycle all outputs 0; rsp_valid never rises;
//    a new request is accepted once RST is low and IDLE is re-entered.
//  6 Gap clamp: req_gap=15, MAX_GAP=14 -> exactly 14 GAP cycles; ALU ERR=0 (no timeout).

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issues one ALU operation per accepted request on an ALU_DESIGN-style port set,
//   optionally splitting operand delivery into an A beat, an idle gap and a B beat.
//   Waits the command-dependent result latency, captures RES and the flags, and
//   returns them on a valid/ready response port.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in idle)
//   req_mode/cmd/opa/opb/cin/split/gap   operation to issue
//   CE MODE CIN CMD INP_VALID OPA OPB     ALU drive
//   RES COUT OFLOW G L E ERR              ALU result and flags
//   rsp_valid/rsp_ready response handshake
//   rsp_res rsp_flags rsp_err             captured result, {COUT,OFLOW,G,L,E}, ERR
module alu_op_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned LAT     = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned MAX_GAP = 14
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mode,
  input  logic [CW-1:0]   req_cmd,
  input  logic [DW-1:0]   req_opa,
  input  logic [DW-1:0]   req_opb,
  input  logic            req_cin,
  input  logic            req_split,
  input  logic [3:0]      req_gap,
  output logic            CE,
  output logic            MODE,
  output logic            CIN,
  output logic [CW-1:0]   CMD,
  output logic [1:0]      INP_VALID,
  output logic [DW-1:0]   OPA,
  output logic [DW-1:0]   OPB,
  input  logic [2*DW-1:0] RES,
  input  logic            COUT,
  input  logic            OFLOW,
  input  logic            G,
  input  logic            L,
  input  logic            E,
  input  logic            ERR,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_res,
  output logic [4:0]      rsp_flags,
  output logic            rsp_err
);

  localparam int unsigned CntW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssueA,
    StGap,
    StIssueB,
    StWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] lat_q;
  logic [3:0]      gap_q;
  logic            mode_q, cin_q, split_q;
  logic [CW-1:0]   cmd_q;
  logic [DW-1:0]   opa_q, opb_q;
  logic [2*DW-1:0] res_q;
  logic [4:0]      flags_q;
  logic            err_q;
  // Low for the first cycle after reset so req_ready stays 0 on that cycle too.
  logic            rdy_en_q;

  logic            accept;
  logic            capture;
  logic            is_mul;
  logic [3:0]      gap_clamped;
  logic [CntW-1:0] lat_sel;

  assign accept      = req_valid && req_ready;
  assign is_mul      = req_mode && ((req_cmd == CW'(9)) || (req_cmd == CW'(10)));
  assign lat_sel     = is_mul ? CntW'(MUL_LAT) : CntW'(LAT);
  assign gap_clamped = (32'(req_gap) > MAX_GAP) ? 4'(MAX_GAP) : req_gap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      rdy_en_q <= 1'b0;
      cnt_q    <= '0;
      lat_q    <= '0;
      gap_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      split_q  <= 1'b0;
      cmd_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      cnt_q    <= cnt_d;
      if (accept) begin
        lat_q   <= lat_sel;
        gap_q   <= gap_clamped;
        mode_q  <= req_mode;
        cin_q   <= req_cin;
        split_q <= req_split;
        cmd_q   <= req_cmd;
        opa_q   <= req_opa;
        opb_q   <= req_opb;
      end
      if (capture) begin
        res_q   <= RES;
        flags_q <= {COUT, OFLOW, G, L, E};
        err_q   <= ERR;
      end
    end
  end

  // Next state. cnt_q counts down the remaining GAP or WAIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = req_split ? StIssueA : StIssueB;
        end
      end
      StIssueA: begin
        if (gap_q != 4'd0) begin
          state_d = StGap;
          cnt_d   = CntW'(gap_q);
        end else begin
          state_d = StIssueB;
        end
      end
      StGap: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIssueB;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StIssueB: begin
        state_d = StWait;
        cnt_d   = lat_q;
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while RST is asserted, independent of the state register.
  always_comb begin
    req_ready = 1'b0;
    CE        = 1'b0;
    MODE      = 1'b0;
    CIN       = 1'b0;
    CMD       = '0;
    INP_VALID = 2'b00;
    OPA       = '0;
    OPB       = '0;
    rsp_valid = 1'b0;
    rsp_res   = '0;
    rsp_flags = '0;
    rsp_err   = 1'b0;
    if (!RST) begin
      req_ready = (state_q == StIdle) && rdy_en_q;
      if (state_q != StIdle) begin
        MODE = mode_q;
        CIN  = cin_q;
        CMD  = cmd_q;
        OPA  = opa_q;
        OPB  = opb_q;
      end
      case (state_q)
        StIssueA: begin
          CE        = 1'b1;
          INP_VALID = 2'b01;
        end
        StGap: CE = 1'b1;
        StIssueB: begin
          CE        = 1'b1;
          INP_VALID = split_q ? 2'b10 : 2'b11;
        end
        StWait: CE = 1'b1;
        StResp: begin
          rsp_valid = 1'b1;
          rsp_res   = res_q;
          rsp_flags = flags_q;
          rsp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU drives RES/flags only in the cycle the
// result is due, a directed vector table covers the called-out cases, then random ops.
module tb_alu_op_sequencer;
  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int LAT     = 1;
  localparam int MUL_LAT = 2;
  localparam int MAX_GAP = 14;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_mode = 1'b0;
  logic [CW-1:0]   req_cmd = '0;
  logic [DW-1:0]   req_opa = '0;
  logic [DW-1:0]   req_opb = '0;
  logic            req_cin = 1'b0;
  logic            req_split = 1'b0;
  logic [3:0]      req_gap = '0;
  logic            CE, MODE, CIN;
  logic [CW-1:0]   CMD;
  logic [1:0]      INP_VALID;
  logic [DW-1:0]   OPA, OPB;
  logic [2*DW-1:0] RES = '0;
  logic            COUT = 1'b0, OFLOW = 1'b0, G = 1'b0, L = 1'b0, E = 1'b0, ERR = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [2*DW-1:0] rsp_res;
  logic [4:0]      rsp_flags;
  logic            rsp_err;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(
    .DW(DW), .CW(CW), .LAT(LAT), .MUL_LAT(MUL_LAT), .MAX_GAP(MAX_GAP)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cmd(req_cmd),
    .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin), .req_split(req_split),
    .req_gap(req_gap),
    .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD), .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ALU behaviour used both by the ALU stand-in and for expected results.
  function automatic logic [2*DW-1:0] alu_fn(input logic mode, input logic [CW-1:0] cmd,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic cin);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    if (mode) begin
      case (cmd)
        4'd0:       return wa + wb;
        4'd1:       return wa - wb;
        4'd2:       return wa + wb + {{(2*DW-1){1'b0}}, cin};
        4'd9, 4'd10: return wa * wb;
        default:    return wa + wb;
      endcase
    end else begin
      case (cmd)
        4'd0:    return wa & wb;
        4'd1:    return wa | wb;
        4'd2:    return wa ^ wb;
        default: return {{DW{1'b0}}, ~(a & b)};
      endcase
    end
  endfunction

  function automatic logic [4:0] flags_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2*DW-1:0] r);
    return {r[DW], r[0], a > b, a < b, a == b};
  endfunction

  function automatic int lat_of(input logic mode, input logic [CW-1:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : LAT;
  endfunction

  // Cycle (1 = cycle after the accept edge) in which rsp_valid first shows.
  function automatic int exp_cycle(input logic split, input logic [3:0] gap,
                                   input logic mode, input logic [CW-1:0] cmd);
    int g;
    g = (int'(gap) > MAX_GAP) ? MAX_GAP : int'(gap);
    return (split ? 1 + g : 0) + 1 + lat_of(mode, cmd) + 1;
  endfunction

  function automatic logic outs_zero();
    return ({req_ready, CE, MODE, CIN, CMD, INP_VALID, OPA, OPB, rsp_valid, rsp_res,
             rsp_flags, rsp_err} === '0);
  endfunction

  // ALU stand-in: RES/flags/ERR carry the real answer only in the last latency cycle
  // after the B beat, and random junk otherwise, so mistimed capture shows up.
  logic [2*DW-1:0] m_res;
  logic [4:0]      m_flags;
  logic [DW-1:0]   m_a = '0;
  logic            m_err, m_show;
  int              m_k = 0, m_cyc = 0, m_acyc = 0;

  always @(negedge CLK) begin
    m_show = 1'b0;
    m_cyc++;
    if (RST || !CE) begin
      m_k = 0;
    end else begin
      if (INP_VALID[0]) begin
        m_a    = OPA;
        m_acyc = m_cyc;
      end
      if (INP_VALID[1]) begin
        m_res   = alu_fn(MODE, CMD, m_a, OPB, CIN);
        m_flags = flags_fn(m_a, OPB, m_res);
        m_err   = (m_cyc - m_acyc) >= 16;
        m_k     = lat_of(MODE, CMD);
      end else if (m_k > 0) begin
        m_k--;
        m_show = (m_k == 0);
      end
    end
    if (m_show) begin
      RES                  = m_res;
      {COUT, OFLOW, G, L, E} = m_flags;
      ERR                  = m_err;
    end else begin
      RES                  = 16'($urandom);
      {COUT, OFLOW, G, L, E} = 5'($urandom);
      ERR                  = 1'($urandom);
    end
  end

  // One full operation starting at a negedge with the sequencer idle; ends at the negedge
  // after the response handshake.
  task automatic run_op(input string tag, input logic mode, input logic [CW-1:0] cmd,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                        input logic split, input logic [3:0] gap, input int hold,
                        input logic [2*DW-1:0] exp_res, input int exp_cyc);
    int n, g;
    bit ok;
    logic [1:0] exp_iv;
    logic [2*DW-1:0] r0;
    logic [4:0] f0;
    g = (int'(gap) > MAX_GAP) ? MAX_GAP : int'(gap);
    req_mode = mode; req_cmd = cmd; req_opa = a; req_opb = b; req_cin = cin;
    req_split = split; req_gap = gap; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      check({tag, ".accept"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    req_valid = 1'b0;
    ok = 1'b1;
    n  = 1;
    while (!rsp_valid && n < 40) begin
      if (split) exp_iv = (n == 1) ? 2'b01 : (n == g + 2) ? 2'b10 : 2'b00;
      else       exp_iv = (n == 1) ? 2'b11 : 2'b00;
      if (INP_VALID !== exp_iv || CE !== 1'b1 || OPA !== a || OPB !== b || MODE !== mode ||
          CMD !== cmd || CIN !== cin || req_ready !== 1'b0) begin
        if (ok) $display("  %s cycle %0d: INP_VALID=%b CE=%b OPA=%0h", tag, n, INP_VALID,
                         CE, OPA);
        ok = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    check({tag, ".trace"}, 32'(ok), 32'd1);
    check({tag, ".latency"}, 32'(n), 32'(exp_cyc));
    if (!rsp_valid) return;
    check({tag, ".res"}, 32'(rsp_res), 32'(exp_res));
    check({tag, ".flags"}, 32'(rsp_flags), 32'(flags_fn(a, b, exp_res)));
    check({tag, ".err"}, 32'(rsp_err), 32'd0);
    r0 = rsp_res;
    f0 = rsp_flags;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid !== 1'b1 || rsp_res !== r0 || rsp_flags !== f0 || req_ready !== 1'b0 ||
          CE !== 1'b0 || INP_VALID !== 2'b00) ok = 1'b0;
      @(negedge CLK);
    end
    if (hold > 0) check({tag, ".hold"}, 32'(ok && rsp_valid === 1'b1 && rsp_res === r0), 32'd1);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check({tag, ".idle"}, 32'({req_ready, rsp_valid, CE, OPA}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
  endtask

  typedef struct {
    string           tag;
    logic            mode;
    logic [CW-1:0]   cmd;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic            cin;
    logic            split;
    logic [3:0]      gap;
    int              hold;
    logic [2*DW-1:0] exp_res;
    int              exp_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int mon_bad;
    logic rm, rc, rs;
    logic [CW-1:0] rcmd;
    logic [DW-1:0] ra, rb;
    logic [3:0] rg;

    vecs[0] = '{"add",      1'b1, 4'd0,  8'd200,  8'd100,  1'b0, 1'b0, 4'd0,  0, 16'h012C, 3};
    vecs[1] = '{"split_g3", 1'b1, 4'd0,  8'd10,   8'd20,   1'b0, 1'b1, 4'd3,  5, 16'h001E, 7};
    vecs[2] = '{"mul9",     1'b1, 4'd9,  8'd5,    8'd6,    1'b0, 1'b0, 4'd0,  0, 16'h001E, 4};
    vecs[3] = '{"and",      1'b0, 4'd0,  8'hF0,   8'h3C,   1'b0, 1'b0, 4'd0,  1, 16'h0030, 3};
    vecs[4] = '{"clamp",    1'b1, 4'd9,  8'd12,   8'd12,   1'b0, 1'b1, 4'd15, 0, 16'h0090, 19};
    vecs[5] = '{"log9",     1'b0, 4'd9,  8'hAA,   8'h0F,   1'b0, 1'b0, 4'd0,  0, 16'h00F5, 3};
    vecs[6] = '{"mul10",    1'b1, 4'd10, 8'hFF,   8'hFF,   1'b0, 1'b0, 4'd0,  2, 16'hFE01, 4};
    vecs[7] = '{"addc_g0",  1'b1, 4'd2,  8'hFF,   8'hFF,   1'b1, 1'b1, 4'd0,  0, 16'h01FF, 4};
    vecs[8] = '{"sub",      1'b1, 4'd1,  8'd5,    8'd7,    1'b0, 1'b0, 4'd0,  0, 16'hFFFE, 3};

    // Reset: outputs low while RST is high and on the cycle after.
    repeat (3) @(negedge CLK);
    check("reset.during", 32'(outs_zero()), 32'd1);
    RST = 1'b0;
    #1;
    check("reset.after", 32'(outs_zero()), 32'd1);
    @(negedge CLK);
    check("reset.ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].tag, vecs[i].mode, vecs[i].cmd, vecs[i].opa, vecs[i].opb, vecs[i].cin,
             vecs[i].split, vecs[i].gap, vecs[i].hold, vecs[i].exp_res, vecs[i].exp_cyc);
    end

    // Reset during WAIT of a split operation.
    req_mode = 1'b1; req_cmd = 4'd0; req_opa = 8'd33; req_opb = 8'd44; req_cin = 1'b0;
    req_split = 1'b1; req_gap = 4'd3; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst.in_wait", 32'({CE, INP_VALID, rsp_valid}), 32'({1'b1, 2'b00, 1'b0}));
    RST = 1'b1;
    #1;
    check("rst.during", 32'(outs_zero()), 32'd1);
    @(negedge CLK);
    check("rst.held", 32'(outs_zero()), 32'd1);
    RST = 1'b0;
    #1;
    check("rst.after", 32'(outs_zero()), 32'd1);
    mon_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0 || CE !== 1'b0) mon_bad++;
    end
    check("rst.no_rsp", 32'(mon_bad), 32'd0);
    run_op("rst.new", 1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 1'b0, 4'd0, 0, 16'd3, 3);

    // Random operations against the reference model.
    for (int t = 0; t < 40; t++) begin
      rm   = 1'($urandom);
      rcmd = ($urandom_range(0, 3) == 0) ? 4'(9 + $urandom_range(0, 1)) : 4'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rs   = 1'($urandom);
      rg   = 4'($urandom);
      run_op($sformatf("rand%0d", t), rm, rcmd, ra, rb, rc, rs, rg, $urandom_range(0, 3),
             alu_fn(rm, rcmd, ra, rb, rc), exp_cycle(rs, rg, rm, rcmd));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
